// File: rtl/dino_pkg.sv
// dino_pkg: shared types and widths for the dino game obstacle path.
package dino_pkg;
    localparam int GAP_W = 10;
    localparam int RND_W = 5;
    typedef enum logic [1:0] {SMALL_CACTUS = 2'd0, LARGE_CACTUS = 2'd1, BIRD = 2'd2} obs_type_t;
    typedef enum logic [1:0] {IDLE, GAP, HOLD, OFFER} spawner_state_t;
endpackage

// File: rtl/obstacle_spawner_if.sv
// obstacle_spawner_if: spawn request handshake between spawner (master) and renderer (slave).
interface obstacle_spawner_if;
    import dino_pkg::*;
    logic spawn_valid;
    logic spawn_ready;
    obs_type_t obs_type;
    modport master(output spawn_valid, obs_type, input spawn_ready);
    modport slave(input spawn_valid, obs_type, output spawn_ready);
endinterface

// File: rtl/spawn_gap_counter.sv
// spawn_gap_counter: loads MIN_GAP + (rnd << GAP_SHIFT), counts ticks down to a terminal value.
module spawn_gap_counter
    import dino_pkg::*;
#(
    parameter int MIN_GAP = 40,
    parameter int GAP_SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [RND_W-1:0] rnd,
    output logic [GAP_W-1:0] cnt,
    output logic             term
);
    assign term = cnt <= GAP_W'(1);
    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= GAP_W'(MIN_GAP) + (GAP_W'(rnd) << GAP_SHIFT);
        else if (dec && cnt != '0) cnt <= cnt - GAP_W'(1);
    end
endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: turns the LFSR stream into gap-timed, capacity-limited spawn requests.
// Define OBSTACLE_SPAWNER_BIRD_EN to let rnd[1:0] = 11 produce birds.
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int MIN_GAP = 40,
    parameter int GAP_SHIFT = 1,
    parameter int MAX_OBS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             tick,
    input  logic [RND_W-1:0] rnd,
    input  logic             obs_done,
    output logic [2:0]       active_cnt,
    obstacle_spawner_if.master sp
);
    localparam logic [2:0] MAX_C = 3'(MAX_OBS);
    spawner_state_t state;
    logic [GAP_W-1:0] gap_cnt;
    logic gap_term, hs, room, go_offer, inc, dec;
    obs_type_t type_next;
    assign hs = sp.spawn_valid && sp.spawn_ready;
    assign room = active_cnt < MAX_C;
    assign go_offer = room && (state == HOLD || (state == GAP && tick && gap_term));
    assign inc = hs && room;
    assign dec = obs_done && active_cnt != 3'd0;
`ifdef OBSTACLE_SPAWNER_BIRD_EN
    assign type_next = rnd[1:0] == 2'b11 ? BIRD : rnd[1] ? LARGE_CACTUS : SMALL_CACTUS;
`else
    assign type_next = rnd[1] ? LARGE_CACTUS : SMALL_CACTUS;
`endif
    spawn_gap_counter #(.MIN_GAP(MIN_GAP), .GAP_SHIFT(GAP_SHIFT)) gap_ctr (
        .clk  (clk),
        .reset(reset),
        .load (run && (state == IDLE || (state == OFFER && hs))),
        .dec  (state == GAP && tick),
        .rnd  (rnd),
        .cnt  (gap_cnt),
        .term (gap_term)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            sp.spawn_valid <= 1'b0;
            sp.obs_type <= SMALL_CACTUS;
        end else if (!run) begin
            state <= IDLE;
            sp.spawn_valid <= 1'b0;
        end else if (go_offer) begin
            state <= OFFER;
            sp.spawn_valid <= 1'b1;
            sp.obs_type <= type_next;
        end else if (state == IDLE) begin
            state <= GAP;
        end else if (state == GAP && tick && gap_term) begin
            state <= HOLD;
        end else if (state == OFFER && hs) begin
            state <= GAP;
            sp.spawn_valid <= 1'b0;
        end
    end
    // A handshake and an obs_done in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!reset) active_cnt <= 3'd0;
        else if (inc && !dec) active_cnt <= active_cnt + 3'd1;
        else if (dec && !inc) active_cnt <= active_cnt - 3'd1;
    end
endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed scenarios plus a randomized soak, checked against a gap/occupancy model.
module tb_obstacle_spawner;
    import dino_pkg::*;
    localparam int MIN_GAP = 40;
    localparam int GAP_SHIFT = 1;
    localparam int MAX_OBS = 3;
    logic clk = 0, reset = 0, run = 0, tick = 0, obs_done = 0;
    logic [4:0] rnd = 0;
    logic [2:0] active_cnt;
    bit armed = 0;
    int n_cmp = 0, n_bad = 0;
    obstacle_spawner_if sp();
    obstacle_spawner #(.MIN_GAP(MIN_GAP), .GAP_SHIFT(GAP_SHIFT), .MAX_OBS(MAX_OBS)) dut (
        .clk(clk), .reset(reset), .run(run), .tick(tick), .rnd(rnd),
        .obs_done(obs_done), .active_cnt(active_cnt), .sp(sp)
    );
    always #5 clk = ~clk;

    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #2 tick = (k % 3 == 0);
            k++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_type(input logic [1:0] r);
`ifdef OBSTACLE_SPAWNER_BIRD_EN
        return r == 2'b11 ? 2 : r == 2'b10 ? 1 : 0;
`else
        return r[1] ? 1 : 0;
`endif
    endfunction

    // Model: ticks remaining until the next obstacle, and how many are on screen.
    typedef enum {M_IDLE, M_GAP, M_WAIT, M_OFFER} mphase_e;
    mphase_e m_ph = M_IDLE;
    int m_left = 0, m_cnt = 0, m_type = 0, nc;
    bit m_valid = 0, hs, room;
    always @(posedge clk) begin
        if (!reset) begin
            m_ph = M_IDLE; m_left = 0; m_cnt = 0; m_valid = 0; m_type = 0;
        end else begin
            hs = m_valid && sp.spawn_ready;
            room = m_cnt < MAX_OBS;
            nc = m_cnt + (hs ? 1 : 0) - ((obs_done && m_cnt > 0) ? 1 : 0);
            if (nc > MAX_OBS) nc = MAX_OBS;
            if (!run) begin
                m_ph = M_IDLE; m_valid = 0;
            end else if (m_ph == M_IDLE) begin
                m_left = MIN_GAP + int'(rnd) * (1 << GAP_SHIFT); m_ph = M_GAP;
            end else if (m_ph == M_GAP && tick) begin
                m_left--;
                if (m_left == 0) m_ph = M_WAIT;
            end else if (m_ph == M_OFFER && hs) begin
                m_left = MIN_GAP + int'(rnd) * (1 << GAP_SHIFT); m_ph = M_GAP; m_valid = 0;
            end
            if (run && m_ph == M_WAIT && room) begin
                m_ph = M_OFFER; m_valid = 1; m_type = exp_type(rnd[1:0]);
            end
            m_cnt = nc;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("spawn_valid", int'(sp.spawn_valid), int'(m_valid));
            check("obs_type", int'(sp.obs_type), m_type);
            check("active_cnt", int'(active_cnt), m_cnt);
        end
    end

    // Returns at the negedge where spawn_valid is first seen high; counts ticks sampled on the way.
    task automatic wait_offer(input string name, output int ticks);
        bit seen = 0;
        ticks = 0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(posedge clk);
            if (tick) ticks++;
            @(negedge clk);
            seen = sp.spawn_valid;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: spawn_valid never rose within 1000 cycles", name);
        end
    endtask

    task automatic take_one();
        int t;
        wait_offer("spawn_wait", t);
        sp.spawn_ready = 1;
        @(posedge clk);
        #2 sp.spawn_ready = 0;
        @(negedge clk);
    endtask

    initial begin
        int t;
        sp.spawn_ready = 0;
        repeat (2) @(posedge clk);
        #2 armed = 1;
        @(negedge clk);
        check("rst_valid", int'(sp.spawn_valid), 0);
        check("rst_type", int'(sp.obs_type), 0);
        check("rst_cnt", int'(active_cnt), 0);
        @(posedge clk);
        #2 reset = 1; rnd = 5; run = 1;
        @(posedge clk);
        wait_offer("start", t);
        check("start_ticks", t, 50);
        check("start_type", int'(sp.obs_type), 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2 rnd = 5'($urandom);
        end
        @(negedge clk);
        check("bp_valid", int'(sp.spawn_valid), 1);
        check("bp_type", int'(sp.obs_type), 0);
        rnd = 7;
        sp.spawn_ready = 1;
        @(posedge clk);
        #2 sp.spawn_ready = 0;
        @(negedge clk);
        check("hs_cnt", int'(active_cnt), 1);
        check("hs_valid", int'(sp.spawn_valid), 0);
        take_one();
        take_one();
        check("cap_cnt", int'(active_cnt), 3);
        repeat (300) @(negedge clk);
        check("hold_valid", int'(sp.spawn_valid), 0);
        obs_done = 1;
        @(posedge clk);
        #2 obs_done = 0;
        @(negedge clk);
        check("hold_cnt", int'(active_cnt), 2);
        check("hold_still", int'(sp.spawn_valid), 0);
        @(negedge clk);
        check("hold_offer", int'(sp.spawn_valid), 1);
`ifdef OBSTACLE_SPAWNER_BIRD_EN
        check("type_11", int'(sp.obs_type), 2);
`else
        check("type_11", int'(sp.obs_type), 1);
`endif
        sp.spawn_ready = 1; obs_done = 1;
        @(posedge clk);
        #2 sp.spawn_ready = 0; obs_done = 0;
        @(negedge clk);
        check("simul_cnt", int'(active_cnt), 2);
        check("simul_valid", int'(sp.spawn_valid), 0);
        obs_done = 1;
        repeat (3) @(posedge clk);
        #2 obs_done = 0;
        @(negedge clk);
        check("floor_cnt", int'(active_cnt), 0);
        rnd = 1;
        wait_offer("type01", t);
        check("type_01", int'(sp.obs_type), 0);
        run = 0;
        @(negedge clk);
        check("abort_valid", int'(sp.spawn_valid), 0);
        rnd = 0; run = 1;
        @(posedge clk);
        wait_offer("restart", t);
        check("restart_ticks", t, 40);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            sp.spawn_ready = 1'($urandom);
            obs_done = ($urandom % 20) == 0;
            rnd = 5'($urandom);
            run = ($urandom % 100) != 0;
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
